// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue.
// Fetches 16-bit instruction words over a single-outstanding req/ack
// memory handshake and buffers them in a small FIFO. The head word is
// presented split into IMM fields. A flush clears the FIFO, redirects
// the fetch address and discards any request already in flight.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no request outstanding; issues one when the FIFO has a free slot
// REQ   | live request outstanding; acked words are written to the FIFO
// DROP  | request outstanding from before a flush; its data is discarded
module inst_prefetch_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [AW-1:0]            flush_addr,
    output logic                     mem_req,
    output logic [AW-1:0]            mem_addr,
    input  logic                     mem_ack,
    input  logic [15:0]              mem_rdata,
    output logic                     inst_valid,
    output logic [15:0]              inst,
    output logic [AW-1:0]            inst_pc,
    output logic [11:0]              imm_lo,
    output logic [3:0]               imm_hi,
    input  logic                     inst_take,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   fetch_pc_q, fetch_pc_d;
    logic            mem_req_q, mem_req_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [15:0]     data_q [DEPTH];
    logic [15:0]     data_d [DEPTH];
    logic [AW-1:0]   pc_q [DEPTH];
    logic [AW-1:0]   pc_d [DEPTH];

    logic            empty;
    logic            full;
    logic            pop;
    logic            push;
    logic [CW:0]     fill_after_ack;
    logic            room_after_ack;

    // FIFO status and the fill level an ack would leave behind this cycle
    always_comb begin
        empty          = (count_q == '0);
        full           = (count_q == DEPTH_C);
        pop            = inst_take && !empty && !flush;
        fill_after_ack = {1'b0, count_q} + (CW+1)'(1) - (CW+1)'(pop);
        room_after_ack = (fill_after_ack < DEPTH_W);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush takes priority over every other event
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!flush && !full) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (flush) begin
                    // An ack in the flush cycle retires the request, so
                    // nothing remains in flight to drop.
                    state_d = mem_ack ? ST_IDLE : ST_DROP;
                end else if (mem_ack && !room_after_ack) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DROP: begin
                // A further flush only moves fetch_pc; the stale request
                // still has to be retired by its ack.
                if (mem_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic: memory interface, fetch address and FIFO write enable
    always_comb begin
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        fetch_pc_d = fetch_pc_q;
        push       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!flush && !full) begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = fetch_pc_q;
                end
            end
            ST_REQ: begin
                if (flush) begin
                    if (mem_ack) begin
                        mem_req_d = 1'b0;
                    end
                end else if (mem_ack) begin
                    push       = 1'b1;
                    fetch_pc_d = mem_addr_q + AW'(1);
                    if (room_after_ack) begin
                        mem_addr_d = mem_addr_q + AW'(1);
                    end else begin
                        mem_req_d = 1'b0;
                    end
                end
            end
            ST_DROP: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                end
            end
            default: begin
                mem_req_d = 1'b0;
            end
        endcase
        if (flush) begin
            fetch_pc_d = flush_addr;
        end
    end

    // FIFO storage, pointers and fill count
    always_comb begin
        data_d   = data_q;
        pc_d     = pc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                data_d[wr_ptr_q] = mem_rdata;
                pc_d[wr_ptr_q]   = mem_addr_q;
                wr_ptr_d         = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            fetch_pc_q <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else begin
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            fetch_pc_q <= fetch_pc_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= data_d[i];
                pc_q[i]   <= pc_d[i];
            end
        end
    end

    // Head-of-queue presentation, forced to zero when empty
    always_comb begin
        inst_valid = !empty;
        inst       = empty ? 16'h0000 : data_q[rd_ptr_q];
        inst_pc    = empty ? '0 : pc_q[rd_ptr_q];
        imm_lo     = inst[11:0];
        imm_hi     = inst[15:12];
        mem_req    = mem_req_q;
        mem_addr   = mem_addr_q;
        count      = count_q;
    end

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Testbench for inst_prefetch_queue: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_inst_prefetch_queue;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [15:0] flush_addr;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        inst_valid;
    logic [15:0] inst;
    logic [15:0] inst_pc;
    logic [11:0] imm_lo;
    logic [3:0]  imm_hi;
    logic        inst_take;
    logic [2:0]  count;

    inst_prefetch_queue #(.DEPTH(DEPTH), .AW(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .flush_addr (flush_addr),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .inst_valid (inst_valid),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .imm_lo     (imm_lo),
        .imm_hi     (imm_hi),
        .inst_take  (inst_take),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: buffered words as queues, plus the fetch bookkeeping.
    logic [15:0] q_data[$];
    logic [15:0] q_pc[$];
    bit          m_req;
    bit          m_stale;
    logic [15:0] m_addr;
    logic [15:0] m_fpc;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q_data.delete();
        q_pc.delete();
        m_req   = 0;
        m_stale = 0;
        m_addr  = 16'h0000;
        m_fpc   = 16'h0000;
    endtask

    task automatic model_update(input bit f, input logic [15:0] fa, input bit a,
                                input logic [15:0] rd, input bit t);
        int pre;
        bit had_req;
        pre     = q_data.size();
        had_req = m_req;
        if (f) begin
            q_data.delete();
            q_pc.delete();
            m_fpc = fa;
            if (had_req && !a) begin
                m_stale = 1;
            end else begin
                m_req   = 0;
                m_stale = 0;
            end
        end else begin
            if (t && pre > 0) begin
                void'(q_data.pop_front());
                void'(q_pc.pop_front());
            end
            if (had_req && a) begin
                if (m_stale) begin
                    m_req   = 0;
                    m_stale = 0;
                end else begin
                    q_data.push_back(rd);
                    q_pc.push_back(m_addr);
                    m_fpc = m_addr + 16'd1;
                    if (q_data.size() < DEPTH) m_addr = m_addr + 16'd1;
                    else m_req = 0;
                end
            end else if (!had_req && pre < DEPTH) begin
                m_req  = 1;
                m_addr = m_fpc;
            end
        end
    endtask

    task automatic check_all();
        logic [15:0] e_inst;
        logic [15:0] e_pc;
        e_inst = (q_data.size() > 0) ? q_data[0] : 16'h0000;
        e_pc   = (q_pc.size() > 0) ? q_pc[0] : 16'h0000;
        check_val("count", 32'(count), 32'(q_data.size()));
        check_val("inst_valid", 32'(inst_valid), 32'(q_data.size() > 0));
        check_val("inst", 32'(inst), 32'(e_inst));
        check_val("inst_pc", 32'(inst_pc), 32'(e_pc));
        check_val("imm_lo", 32'(imm_lo), 32'(e_inst[11:0]));
        check_val("imm_hi", 32'(imm_hi), 32'(e_inst[15:12]));
        check_val("mem_req", 32'(mem_req), 32'(m_req));
        if (m_req) check_val("mem_addr", 32'(mem_addr), 32'(m_addr));
    endtask

    // One clock: drive at negedge, update model at posedge, check at next negedge.
    task automatic step(input bit f, input logic [15:0] fa, input bit a,
                        input logic [15:0] rd, input bit t);
        flush      = f;
        flush_addr = fa;
        mem_ack    = a;
        mem_rdata  = rd;
        inst_take  = t;
        @(posedge clk);
        model_update(f, fa, a, rd, t);
        @(negedge clk);
        check_all();
    endtask

    task automatic stream(input int n, input int take_mode);
        for (int i = 0; i < n; i++) begin
            step(0, 16'h0000, m_req, 16'hA000 + m_addr,
                 (take_mode == 1) ? (i % 3 != 0) : 1'b0);
        end
    endtask

    initial begin
        int n_ack;
        rst        = 1'b1;
        flush      = 1'b0;
        flush_addr = 16'h0000;
        mem_ack    = 1'b0;
        mem_rdata  = 16'h0000;
        inst_take  = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_all();

        // Reset asserted mid-transfer with words buffered
        stream(3, 0);
        #2 rst = 1'b1;
        #1;
        check_val("rst_mem_req", 32'(mem_req), 32'd0);
        check_val("rst_valid", 32'(inst_valid), 32'd0);
        check_val("rst_inst", 32'(inst), 32'd0);
        check_val("rst_count", 32'(count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_all();

        // Streaming until full, no takes
        n_ack = 0;
        for (int i = 0; i < 8; i++) begin
            if (m_req) begin
                check_val("stream_addr", 32'(mem_addr), 32'(n_ack));
                n_ack++;
            end
            step(0, 16'h0000, m_req, 16'hA000 + m_addr, 0);
        end
        check_val("full_count", 32'(count), 32'd4);
        check_val("full_req", 32'(mem_req), 32'd0);
        check_val("full_inst", 32'(inst), 32'h0000A000);
        check_val("full_imm_hi", 32'(imm_hi), 32'hA);
        check_val("full_imm_lo", 32'(imm_lo), 32'h000);

        // Take from full, then take together with ack
        step(0, 16'h0000, 0, 16'h0000, 1);
        check_val("take_count", 32'(count), 32'd3);
        step(0, 16'h0000, 0, 16'h0000, 0);
        check_val("refill_req", 32'(mem_req), 32'd1);
        check_val("refill_addr", 32'(mem_addr), 32'h4);
        step(0, 16'h0000, 1, 16'hA004, 1);
        check_val("take_ack_count", 32'(count), 32'd3);

        // Flush with a request pending, stale ack three cycles later
        step(1, 16'h0040, 0, 16'h0000, 0);
        step(0, 16'h0000, 0, 16'h0000, 0);
        step(0, 16'h0000, 0, 16'h0000, 0);
        step(0, 16'h0000, 1, 16'hDEAD, 0);
        check_val("drop_count", 32'(count), 32'd0);
        step(0, 16'h0000, 0, 16'h0000, 0);
        check_val("redirect_addr", 32'(mem_addr), 32'h40);
        step(0, 16'h0000, 1, 16'hA040, 0);
        check_val("redirect_pc", 32'(inst_pc), 32'h40);

        // Flush coincident with ack, then two flushes around a dropped request
        step(1, 16'h0060, 1, 16'hDEAD, 0);
        check_val("flush_ack_count", 32'(count), 32'd0);
        check_val("flush_ack_req", 32'(mem_req), 32'd0);
        step(0, 16'h0000, 0, 16'h0000, 0);
        check_val("flush_ack_addr", 32'(mem_addr), 32'h60);
        step(1, 16'h0070, 0, 16'h0000, 0);
        step(1, 16'h0080, 0, 16'h0000, 0);
        step(0, 16'h0000, 1, 16'hBEEF, 0);
        stream(6, 0);
        check_val("drop_first_pc", 32'(inst_pc), 32'h80);
        check_val("drop_first_inst", 32'(inst), 32'hA080);

        // Address and pointer wrap with interleaved takes
        step(1, 16'hFFFE, 0, 16'h0000, 0);
        stream(30, 1);

        // Randomized traffic, including acks with no request
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 16) == 0, 16'($urandom), ($urandom % 3) != 0,
                 16'($urandom), ($urandom % 2) == 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
